// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, sample-edge selection and word-width helpers.
package spi_pkg;

  // Widest word any SPI block in this family handles.
  localparam int SPI_MAX_WORD_WIDTH = 64;

  // Width of a counter able to hold 0..SPI_MAX_WORD_WIDTH.
  localparam int SPI_CNT_WIDTH = $clog2(SPI_MAX_WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_t;

  // Modes 0 and 3 sample on rising sclk, modes 1 and 2 on falling sclk.
  function automatic logic spi_sample_on_rise(spi_mode_t mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

  // Requested width 0 or wider than max_w means "use max_w".
  function automatic logic [SPI_CNT_WIDTH-1:0] spi_eff_width(logic [5:0] req, int unsigned max_w);
    if ((req == 6'd0) || (32'(req) > max_w)) begin
      return SPI_CNT_WIDTH'(max_w);
    end
    return SPI_CNT_WIDTH'(req);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer bank with a per-bit reset value; all bits see identical delay.
module spi_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two register stages to resolve metastability on asynchronous inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_rx.sv
// SPI receiver: oversamples sclk/rxd/cs_n in the clk domain and emits words on AXI-Stream.
module spi_rx
  import spi_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       rxd,
  input  logic                       cs_n,
  input  logic [1:0]                 spi_mode,
  input  logic [5:0]                 spi_word_width,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic                       overrun,
  output logic                       frame_error
);

  localparam int AW = AXIS_DATA_WIDTH;
  localparam int CW = SPI_CNT_WIDTH;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RECV = 1'b1;

  // Synchronized copies of the asynchronous SPI pins.
  logic [2:0] pins_async;
  logic [2:0] pins_sync;
  logic       sclk_s;
  logic       rxd_s;
  logic       cs_n_s;

  assign pins_async = {sclk, rxd, cs_n};

  // sclk and rxd share one bank so their delays match; cs_n resets to inactive.
  spi_sync #(
    .WIDTH    (3),
    .RESET_VAL(3'b001)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (pins_async),
    .q_o   (pins_sync)
  );

  assign sclk_s = pins_sync[2];
  assign rxd_s  = pins_sync[1];
  assign cs_n_s = pins_sync[0];

  // Edge-detection front end.
  logic       sclk_prev_q;
  logic [1:0] warmup_q;
  logic       edge_q;
  logic       bit_q;
  logic       sample_edge;

  // Pick the mode's sampling edge; suppressed until the warmup counter saturates.
  always_comb begin
    sample_edge = 1'b0;
    if (warmup_q == 2'd3) begin
      if (spi_sample_on_rise(spi_mode_t'(spi_mode))) begin
        sample_edge = sclk_s & ~sclk_prev_q;
      end else begin
        sample_edge = ~sclk_s & sclk_prev_q;
      end
    end
  end

  // Register the edge strobe together with the data bit seen at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      warmup_q    <= 2'd0;
      edge_q      <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      warmup_q    <= (warmup_q == 2'd3) ? 2'd3 : warmup_q + 2'd1;
      edge_q      <= sample_edge;
      bit_q       <= rxd_s;
    end
  end

  // Framing, deserialization and output-hold state.
  logic          state_q,       state_d;
  logic [CW-1:0] bit_cnt_q,     bit_cnt_d;
  logic [CW-1:0] width_q,       width_d;
  logic [AW-1:0] shift_q,       shift_d;
  logic [AW-1:0] tdata_q,       tdata_d;
  logic          tvalid_q,      tvalid_d;
  logic          overrun_q,     overrun_d;
  logic          frame_error_q, frame_error_d;

  logic [AW-1:0] shift_next;
  logic [CW-1:0] width_req;
  logic          word_done;
  logic          handshake;

  // Next-state logic: shift bits in, complete words, and arbitrate the single output slot.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    width_d       = width_q;
    shift_d       = shift_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    overrun_d     = 1'b0;
    frame_error_d = 1'b0;
    word_done     = 1'b0;

    // Shift register is cleared at every word boundary, so this is already zero-extended.
    shift_next = (shift_q << 1) | AW'(bit_q);
    width_req  = spi_eff_width(spi_word_width, AW);
    handshake  = tvalid_q & m_axis_tready;

    if (handshake) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!cs_n_s) begin
          state_d   = ST_RECV;
          width_d   = width_req;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_RECV: begin
        if (cs_n_s) begin
          // Frame ended; any partial word is thrown away.
          state_d       = ST_IDLE;
          bit_cnt_d     = '0;
          shift_d       = '0;
          frame_error_d = (bit_cnt_q != '0);
        end else if (edge_q) begin
          if ((bit_cnt_q + CW'(1)) == width_q) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            width_d   = width_req;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = shift_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A free slot (or one emptied this cycle) takes the new word; otherwise it is dropped.
    if (word_done) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = shift_next;
        tvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers; width defaults to the full tdata width out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      width_q       <= CW'(AW);
      shift_q       <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      width_q       <= width_d;
      shift_q       <= shift_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q == ST_RECV);
  assign overrun       = overrun_q;
  assign frame_error   = frame_error_q;

endmodule

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 8, meaning maximum word width and tdata width (1..64).
REQ-002 SHALL have ports:
  clk  input  1  system clock; all logic on posedge
  rst_n  input  1  reset, asynchronous, active-low
  sclk  input  1  SPI clock from remote transmitter, asynchronous to clk
  rxd  input  1  serial data, MSB first
  cs_n  input  1  frame select, active-low; may be tied low
  spi_mode  input  2  mode 0..3; stable while cs_n high
  spi_word_width  input  6  bits per word; sampled at frame start and after each completed word
  m_axis_tdata  output  AXIS_DATA_WIDTH  received word, right-aligned
  m_axis_tvalid  output  1  output word valid
  m_axis_tready  input  1  downstream ready
  busy  output  1  frame in progress (synchronized cs_n low)
  overrun  output  1  one-cycle pulse: completed word dropped
  frame_error  output  1  one-cycle pulse: cs_n rose mid-word

Function
REQ-003 sclk, rxd, cs_n SHALL each pass a 2-flop synchronizer; rxd and sclk SHALL have identical delay.
REQ-004 Sampling edge SHALL be rising sclk for modes 0 and 3, falling for modes 1 and 2.
REQ-005 Edge detect SHALL compare synchronized sclk with its previous registered value; edges SHALL be ignored until 3 clk cycles after reset release (2-bit warmup counter).
REQ-006 Correct operation SHALL require sclk half-period >= 2 clk periods.
REQ-007 States: IDLE (cs_n sync high, bit counter 0), RECV (accumulating bits); IDLE->RECV on cs_n sync low; RECV->IDLE on cs_n sync high.
REQ-008 Each sampling edge in RECV SHALL shift rxd into the LSB of the shift register and increment the bit counter.
REQ-009 Effective width W SHALL be spi_word_width latched on IDLE->RECV and on each word completion; 0 or >AXIS_DATA_WIDTH SHALL be treated as AXIS_DATA_WIDTH.
REQ-010 When bit counter reaches W, tdata SHALL load the W-bit word zero-extended, the counter SHALL clear, and the block SHALL stay in RECV.
REQ-011 Latency: m_axis_tvalid SHALL rise at the 3rd clk posedge after the posedge that first registers the final raw sampling edge.
REQ-012 tvalid SHALL remain high and tdata stable until a cycle with tvalid and tready both high; tvalid then SHALL drop unless REQ-013 applies.
REQ-013 Word completion in the same cycle as a handshake SHALL load the new word with tvalid remaining high.
REQ-014 Word completion while tvalid high and no handshake SHALL drop the new word, keep the held word, and pulse overrun.
REQ-015 cs_n sync rising with bit counter nonzero SHALL discard the partial word and pulse frame_error; with counter zero, no pulse.
REQ-016 With cs_n tied low, words SHALL be framed purely by counting W sampling edges from the end of warmup.
REQ-017 busy SHALL equal state==RECV.

Reset
REQ-018 rst_n low SHALL immediately force: tdata 0, tvalid 0, overrun 0, frame_error 0, busy 0, state IDLE, counters 0, shift register 0, latched W = AXIS_DATA_WIDTH, synchronizers (cs_n 1, sclk 0, rxd 0), warmup 0.
REQ-019 Reset mid-word SHALL discard all partial data; no output beat follows reset release until a full new word is received.

Structure
REQ-020 Shared package spi_pkg SHALL hold the SPI mode typedef, sample-edge-by-mode function, and SPI_MAX_WORD_WIDTH = 64 constant; spi_tx and spi_rx SHALL both use it.
REQ-021 One sub-module, spi_sync (parameterized width and per-bit reset value, 2-flop), SHALL implement REQ-003.

Verification
REQ-022 Mode 0, W=8, cs_n low, send 0xA5, tready=1 -> single beat tdata=0xA5, no overrun/frame_error.
REQ-023 AXIS_DATA_WIDTH=16, mode 3, W=12, send 0xABC -> tdata=0x0ABC; repeat modes 1, 2 -> same value.
REQ-024 tready=0, send 0x11 then 0x22 -> tdata holds 0x11, one overrun pulse at 0x22 completion; raise tready -> exactly one beat 0x11.
REQ-025 cs_n raised after 5 bits -> one frame_error pulse, no beat; next frame 0x3C -> tdata=0x3C.
REQ-026 rst_n low after 4 bits -> all outputs 0 same cycle; after release, full word 0x5A -> tdata=0x5A only.
REQ-027 Loopback from spi_tx, cs_n tied low, all 4 modes, sclk_prescale=8, W=8, 256 random words -> received stream equals sent stream.
